skid_buffer: RTL and testbench

//   Two-entry valid/ready pipeline stage. Breaks the combinational path on

---
 rtl/skid_buffer.sv | 106 ++++++++++
 tb/tb_skid_buffer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer with every output driven from a flop.
// Define SKID_BUFFER_STATS_EN to add the xfer_count/stall_count statistics outputs.
module skid_buffer #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [1:0]       occupancy
`ifdef SKID_BUFFER_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0] xfer_count,
   output logic [CNT_WIDTH-1:0] stall_count
`endif
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] BUSY  = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_params
      $error("skid_buffer: WIDTH and CNT_WIDTH must both be >= 1");
   end

   logic [1:0]       state;
   logic [WIDTH-1:0] skid;
   logic             in_fire;
   logic             out_fire;

   assign in_fire   = s_valid & s_ready;
   assign out_fire  = m_valid & m_ready;
   // The state encoding is the entry count itself.
   assign occupancy = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= EMPTY;
         s_ready <= 1'b0;
         m_valid <= 1'b0;
         m_data  <= '0;
         skid    <= '0;
      end else begin
         case (state)
            EMPTY: begin
               // s_ready is still low for the first cycle after reset.
               s_ready <= 1'b1;
               if (in_fire) begin
                  m_data  <= s_data;
                  m_valid <= 1'b1;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (in_fire && out_fire) begin
                  m_data <= s_data;
               end else if (in_fire) begin
                  skid    <= s_data;
                  s_ready <= 1'b0;
                  state   <= FULL;
               end else if (out_fire) begin
                  m_valid <= 1'b0;
                  state   <= EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  m_data  <= skid;
                  s_ready <= 1'b1;
                  state   <= BUSY;
               end
            end
            default: begin
               state   <= EMPTY;
               s_ready <= 1'b1;
               m_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef SKID_BUFFER_STATS_EN
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   // Transfers wrap; stalls saturate at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xfer_count  <= '0;
         stall_count <= '0;
      end else begin
         if (out_fire) begin
            xfer_count <= xfer_count + CNT_ONE;
         end
         if (m_valid && !m_ready && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_ONE;
         end
      end
   end
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// Bench for skid_buffer: directed steps plus random traffic against a queue model
// of the buffer contents (entries held = accepted words not yet delivered).
module tb_skid_buffer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_data;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic [1:0] occupancy;
`ifdef SKID_BUFFER_STATS_EN
   logic [3:0] xfer_count;
   logic [3:0] stall_count;
`endif

   skid_buffer #(.WIDTH(8), .CNT_WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .occupancy (occupancy)
`ifdef SKID_BUFFER_STATS_EN
      ,
      .xfer_count  (xfer_count),
      .stall_count (stall_count)
`endif
   );

   always #5 clk = ~clk;

   int         vecs = 0;
   int         errs = 0;
   bit         checking = 1'b0;
   logic [7:0] q[$];
   bit         ready_en = 1'b0;
   bit         data_zero = 1'b1;
   int         exp_xfer = 0;
   int         exp_stall = 0;
   int         delivered = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      if (checking) begin
         chk("s_ready", {31'd0, s_ready}, {31'd0, (ready_en && q.size() < 2)});
         chk("m_valid", {31'd0, m_valid}, {31'd0, (q.size() > 0)});
         chk("occupancy", {30'd0, occupancy}, q.size());
         if (q.size() > 0) chk("m_data", {24'd0, m_data}, {24'd0, q[0]});
         else if (data_zero) chk("m_data_rst", {24'd0, m_data}, 32'd0);
`ifdef SKID_BUFFER_STATS_EN
         chk("xfer_count", {28'd0, xfer_count}, exp_xfer);
         chk("stall_count", {28'd0, stall_count}, exp_stall);
`endif
      end
   endtask

   // One clock: check current outputs, drive inputs, advance the model, step.
   task automatic cycle(input logic rn, input logic sv, input logic [7:0] sd, input logic mr);
      bit exp_ready;
      bit exp_valid;
      check_outputs();
      rst_n   = rn;
      s_valid = sv;
      s_data  = sd;
      m_ready = mr;
      exp_ready = ready_en && (q.size() < 2);
      exp_valid = (q.size() > 0);
      if (!rn) begin
         q.delete();
         ready_en  = 1'b0;
         data_zero = 1'b1;
         exp_xfer  = 0;
         exp_stall = 0;
      end else begin
         if (exp_valid && mr) begin
            void'(q.pop_front());
            exp_xfer = (exp_xfer + 1) % 16;
            delivered++;
         end
         if (exp_valid && !mr && exp_stall < 15) exp_stall++;
         if (exp_ready && sv) begin
            q.push_back(sd);
            data_zero = 1'b0;
         end
         ready_en = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'h00;
      m_ready = 1'b0;
      @(negedge clk);

      // Reset held for two clocks, then released.
      cycle(1'b0, 1'b1, 8'h5A, 1'b1);
      cycle(1'b0, 1'b1, 8'h5A, 1'b1);
      checking = 1'b1;
      chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
      chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_occ", {30'd0, occupancy}, 32'd0);
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      chk("rel_s_ready", {31'd0, s_ready}, 32'd1);

      // Streaming 0x01..0x10 with m_ready high: no bubbles.
      delivered = 0;
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, 1'b1, 8'(i), 1'b1);
         chk("stream_m_valid", {31'd0, m_valid}, 32'd1);
         chk("stream_m_data", {24'd0, m_data}, i);
      end
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      chk("stream_count", delivered, 32'd16);
      chk("stream_empty", {31'd0, m_valid}, 32'd0);

      // Backpressure: third word refused while full.
      cycle(1'b1, 1'b1, 8'hA1, 1'b0);
      cycle(1'b1, 1'b1, 8'hA2, 1'b0);
      cycle(1'b1, 1'b1, 8'hA3, 1'b0);
      chk("bp_occ", {30'd0, occupancy}, 32'd2);
      chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
      chk("bp_m_data", {24'd0, m_data}, 32'hA1);
      cycle(1'b1, 1'b1, 8'hA3, 1'b1);
      chk("bp_out2", {24'd0, m_data}, 32'hA2);
      cycle(1'b1, 1'b1, 8'hA3, 1'b1);
      chk("bp_out3", {24'd0, m_data}, 32'hA3);
      cycle(1'b1, 1'b0, 8'h00, 1'b1);

      // Drain from FULL.
      cycle(1'b1, 1'b1, 8'hB1, 1'b0);
      cycle(1'b1, 1'b1, 8'hB2, 1'b0);
      chk("drain_full", {30'd0, occupancy}, 32'd2);
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      chk("drain_occ1", {30'd0, occupancy}, 32'd1);
      chk("drain_data", {24'd0, m_data}, 32'hB2);
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      chk("drain_occ0", {30'd0, occupancy}, 32'd0);
      chk("drain_m_valid", {31'd0, m_valid}, 32'd0);

      // Random traffic with varying bias and one mid-run reset.
      for (int n = 0; n < 10000; n++) begin
         int vb;
         int rb;
         vb = (n / 1000) % 4;
         rb = ((n / 700) % 3) + 1;
         cycle((n == 5003) ? 1'b0 : 1'b1,
               1'($urandom_range(0, 3) < vb + 1),
               8'($urandom),
               1'($urandom_range(0, 3) < rb));
      end
      for (int n = 0; n < 3; n++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
      chk("rand_drained", {30'd0, occupancy}, 32'd0);

`ifdef SKID_BUFFER_STATS_EN
      // Counters with CNT_WIDTH=4: 20 transfers wrap to 4, 20 stalls saturate at 15.
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 8'(i), 1'b1);
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      chk("stats_xfer", {28'd0, xfer_count}, 32'd4);
      cycle(1'b1, 1'b1, 8'h55, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
      chk("stats_stall", {28'd0, stall_count}, 32'd15);
`endif

      check_outputs();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
